// File: rtl/conv_weights_ddr_loader_pkg.sv
// conv_weights_ddr_loader_pkg
//   Shared widths and the loader FSM state type for the conv weight
//   DDR loader (conv_weights_ddr_loader and weights_beat_packer).
package conv_weights_ddr_loader_pkg;

    localparam int unsigned WEIGHT_WORD_LENGTH = 512;  // 64 weights x 8 bit
    localparam int unsigned DDR_BEAT_WIDTH     = 64;
    localparam int unsigned WEIGHT_ADR_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } load_state_t;

endpackage

// File: rtl/conv_weights_ddr_loader_packer.sv
// weights_beat_packer
//   Packs narrow DDR beats into one full weight word. Lane 0 occupies the
//   least significant beat_width bits. word_full presents the stored lanes
//   merged with the beat being accepted, so the word is usable in the same
//   cycle its last lane arrives.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          restart packing at lane 0 and drop any partial word
//   beat_accept    a beat is transferred this cycle
//   beat_data      beat payload
//   word_full      packed word including the current beat
//   word_complete  high when the accepted beat fills the last lane
module weights_beat_packer #(
    parameter int unsigned word_length = 512,
    parameter int unsigned beat_width  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   beat_accept,
    input  logic [beat_width-1:0]  beat_data,
    output logic [word_length-1:0] word_full,
    output logic                   word_complete
);

    localparam int unsigned BEATS    = word_length / beat_width;
    localparam int unsigned CNT_W    = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]       beat_cnt;
    logic [word_length-1:0] pack_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            beat_cnt <= '0;
            pack_q   <= '0;
        end else if (beat_accept) begin
            pack_q[beat_cnt*beat_width +: beat_width] <= beat_data;
            beat_cnt <= (beat_cnt == LAST_LANE) ? '0 : beat_cnt + 1'b1;
        end
    end

    always_comb begin
        word_full = pack_q;
        word_full[beat_cnt*beat_width +: beat_width] = beat_data;
    end

    assign word_complete = beat_accept && (beat_cnt == LAST_LANE);

endmodule

// File: rtl/conv_weights_ddr_loader.sv
// conv_weights_ddr_loader
//   Write-side producer for the ping-pong conv weight buffer. Accepts a DDR
//   beat stream, packs beats into weight words and writes them at
//   consecutive buffer addresses starting at load_base_adr (wrapping mod
//   2^16). load_done pulses once the final word has been written.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   load_start                  start pulse (sampled in IDLE only)
//   load_word_count             words to load, sampled with load_start
//   load_base_adr               first buffer address, sampled with load_start
//   ddr_valid/ddr_ready         beat handshake
//   ddr_data, ddr_last          beat payload, DMA end-of-tile marker
//   weights_word_buf_en_wt      one-cycle buffer write strobe
//   weights_word_buf_adr_wt     buffer write address
//   weights_word_buf_wt         buffer write data
//   load_busy, load_done        load in progress, completion pulse
//   load_error                  sticky ddr_last mismatch flag
// Configuration:
//   WEIGHTS_LOADER_LAST_CHECK_EN  when defined, ddr_last is checked against
//   the expected final beat; otherwise ddr_last is ignored and load_error=0.
module conv_weights_ddr_loader
    import conv_weights_ddr_loader_pkg::*;
#(
    parameter int unsigned weight_word_length = WEIGHT_WORD_LENGTH,
    parameter int unsigned ddr_beat_width     = DDR_BEAT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_start,
    input  logic [15:0]                   load_word_count,
    input  logic [WEIGHT_ADR_WIDTH-1:0]   load_base_adr,
    input  logic                          ddr_valid,
    output logic                          ddr_ready,
    input  logic [ddr_beat_width-1:0]     ddr_data,
    input  logic                          ddr_last,
    output logic                          weights_word_buf_en_wt,
    output logic [WEIGHT_ADR_WIDTH-1:0]   weights_word_buf_adr_wt,
    output logic [weight_word_length-1:0] weights_word_buf_wt,
    output logic                          load_busy,
    output logic                          load_done,
    output logic                          load_error
);

    load_state_t                 state;
    logic [15:0]                 count_q;
    logic [WEIGHT_ADR_WIDTH-1:0] base_q;
    logic [15:0]                 word_idx;

    logic                          start_accept;
    logic                          beat_accept;
    logic                          last_word;
    logic [weight_word_length-1:0] word_full;
    logic                          word_complete;

    assign start_accept = (state == ST_IDLE) && load_start;
    assign beat_accept  = (state == ST_STREAM) && ddr_valid && ddr_ready;
    assign last_word    = (word_idx == count_q - 16'd1);

    weights_beat_packer #(
        .word_length (weight_word_length),
        .beat_width  (ddr_beat_width)
    ) u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_accept),
        .beat_accept   (beat_accept),
        .beat_data     (ddr_data),
        .word_full     (word_full),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= ST_IDLE;
            count_q                 <= '0;
            base_q                  <= '0;
            word_idx                <= '0;
            ddr_ready               <= 1'b0;
            weights_word_buf_en_wt  <= 1'b0;
            weights_word_buf_adr_wt <= '0;
            weights_word_buf_wt     <= '0;
            load_busy               <= 1'b0;
            load_done               <= 1'b0;
        end else begin
            weights_word_buf_en_wt <= 1'b0;
            load_done              <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        count_q   <= load_word_count;
                        base_q    <= load_base_adr;
                        word_idx  <= '0;
                        load_busy <= 1'b1;
                        if (load_word_count == 16'd0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_STREAM;
                            ddr_ready <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (word_complete) begin
                        weights_word_buf_en_wt  <= 1'b1;
                        weights_word_buf_adr_wt <= base_q + word_idx;
                        weights_word_buf_wt     <= word_full;
                        word_idx                <= word_idx + 16'd1;
                        if (last_word) begin
                            ddr_ready <= 1'b0;
                            state     <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // final write strobe is on the bus this cycle
                    load_busy <= 1'b0;
                    load_done <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    // Arriving from FLUSH, load_done is already high here.
                    // A zero-word load arrives still busy and spends one extra
                    // cycle here so its done pulse lands two cycles after start.
                    if (load_busy) begin
                        load_busy <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WEIGHTS_LOADER_LAST_CHECK_EN
    logic load_error_q;
    logic expect_last;

    assign expect_last = word_complete && last_word;

    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            load_error_q <= 1'b0;
        end else if (beat_accept && (ddr_last != expect_last)) begin
            load_error_q <= 1'b1;
        end
    end

    assign load_error = load_error_q;
`else
    logic unused_ddr_last;
    assign unused_ddr_last = ddr_last;
    assign load_error      = 1'b0;
`endif

endmodule

// File: tb/tb_conv_weights_ddr_loader.sv
// Self-checking bench for conv_weights_ddr_loader: directed cases plus
// randomized loads compared against a word-list reference model.
module tb_conv_weights_ddr_loader;

    localparam int unsigned WW = 512;
    localparam int unsigned BW = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           load_start;
    logic [15:0]    load_word_count;
    logic [15:0]    load_base_adr;
    logic           ddr_valid;
    logic           ddr_ready;
    logic [BW-1:0]  ddr_data;
    logic           ddr_last;
    logic           en_wt;
    logic [15:0]    adr_wt;
    logic [WW-1:0]  wt;
    logic           load_busy;
    logic           load_done;
    logic           load_error;

    always #5 clk = ~clk;

    conv_weights_ddr_loader #(
        .weight_word_length (WW),
        .ddr_beat_width     (BW)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .load_start              (load_start),
        .load_word_count         (load_word_count),
        .load_base_adr           (load_base_adr),
        .ddr_valid               (ddr_valid),
        .ddr_ready               (ddr_ready),
        .ddr_data                (ddr_data),
        .ddr_last                (ddr_last),
        .weights_word_buf_en_wt  (en_wt),
        .weights_word_buf_adr_wt (adr_wt),
        .weights_word_buf_wt     (wt),
        .load_busy               (load_busy),
        .load_done               (load_done),
        .load_error              (load_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0]   adr;
        logic [WW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           exp_wr;
    logic [15:0]   last_adr;
    logic [WW-1:0] last_data;

    task automatic check(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the next expected word,
    // and address/data must hold between strobes.
    always @(negedge clk) begin
        if (reset) begin
            last_adr  = '0;
            last_data = '0;
        end else if (en_wt) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                exp_wr = exp_q.pop_front();
                check("wr_adr", adr_wt, exp_wr.adr);
                check("wr_data", wt, exp_wr.data);
            end
            last_adr  = adr_wt;
            last_data = wt;
        end else begin
            check("adr_hold", adr_wt, last_adr);
            check("data_hold", wt, last_data);
        end
    end

    function automatic logic exp_err_for(input int bad_beat);
`ifdef WEIGHTS_LOADER_LAST_CHECK_EN
        return bad_beat >= 0;
`else
        return 1'b0;
`endif
    endfunction

    // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
    // bad_beat: beat index whose ddr_last is inverted (-1 = none).
    task automatic do_load(input int count, input logic [15:0] base, input int gap_mode,
                           input int bad_beat, input bit idx_data);
        logic [BW-1:0] beats[$];
        logic [WW-1:0] word;
        logic [BW-1:0] bv;
        int total;
        int b;
        int cyc;
        logic vld;
        logic acc;
        wr_t e;

        total = count * 8;
        for (int w = 0; w < count; w++) begin
            word = '0;
            for (int k = 0; k < 8; k++) begin
                bv = idx_data ? BW'(w * 8 + k) : {$urandom, $urandom};
                beats.push_back(bv);
                word[k*BW +: BW] = bv;
            end
            e.adr  = base + 16'(w);
            e.data = word;
            exp_q.push_back(e);
        end

        @(negedge clk);
        load_start      = 1'b1;
        load_word_count = 16'(count);
        load_base_adr   = base;
        @(negedge clk);
        load_start = 1'b0;
        check("ready_after_start", ddr_ready, count != 0);
        check("busy_after_start", load_busy, 1);
        check("error_cleared", load_error, 0);

        if (count == 0) begin
            check("zero_done_t1", load_done, 0);
            @(negedge clk);
            check("zero_done_t2", load_done, 1);
            check("zero_busy_t2", load_busy, 0);
            check("zero_ready", ddr_ready, 0);
            @(negedge clk);
            check("zero_done_pulse", load_done, 0);
            return;
        end

        b   = 0;
        cyc = 0;
        while (b < total && cyc < 4000) begin
            case (gap_mode)
                0:       vld = 1'b1;
                1:       vld = (cyc % 2) == 0;
                default: vld = $urandom_range(99) >= 30;
            endcase
            ddr_valid = vld;
            ddr_data  = beats[b];
            ddr_last  = (b == total - 1) ^ (b == bad_beat);
            // stray start pulses while streaming must be ignored
            load_start      = (gap_mode == 2) && ($urandom_range(9) == 0);
            load_word_count = 16'($urandom);
            if (!ddr_ready) check("ready_in_stream", ddr_ready, 1);
            acc = vld && ddr_ready;
            @(negedge clk);
            cyc++;
            if (acc) b++;
        end
        ddr_valid  = 1'b0;
        ddr_last   = 1'b0;
        load_start = 1'b0;
        if (b < total) check("stream_timeout", 32'(b), 32'(total));

        check("final_en_t1", en_wt, 1);
        check("ready_drop_t1", ddr_ready, 0);
        check("done_t1", load_done, 0);
        @(negedge clk);
        check("done_t2", load_done, 1);
        check("busy_t2", load_busy, 0);
        check("error_flag", load_error, exp_err_for(bad_beat));
        check("writes_consumed", 32'(exp_q.size()), 0);
        @(negedge clk);
        check("done_pulse", load_done, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, ddr_ready, 0);
        check({tag, "_en"}, en_wt, 0);
        check({tag, "_adr"}, adr_wt, 0);
        check({tag, "_wt"}, wt, 0);
        check({tag, "_busy"}, load_busy, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_error"}, load_error, 0);
    endtask

    initial begin
        reset           = 1'b1;
        load_start      = 1'b0;
        load_word_count = '0;
        load_base_adr   = '0;
        ddr_valid       = 1'b0;
        ddr_data        = '0;
        ddr_last        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // beats offered while idle are not accepted
        ddr_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ready", ddr_ready, 0);
        end
        ddr_valid = 1'b0;

        do_load(2, 16'h0010, 0, -1, 1'b1);
        do_load(1, 16'h1234, 1, -1, 1'b1);
        do_load(2, 16'hFFFF, 0, -1, 1'b0);
        do_load(0, 16'h0042, 0, -1, 1'b0);

        // reset in the middle of word 0
        @(negedge clk);
        load_start      = 1'b1;
        load_word_count = 16'd1;
        load_base_adr   = 16'h0300;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ddr_valid = 1'b1;
            ddr_data  = {$urandom, $urandom};
            @(negedge clk);
        end
        ddr_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;
        do_load(1, 16'h0300, 0, -1, 1'b0);

        // ddr_last asserted early on beat 7 of a 2-word load, then cleared
        do_load(2, 16'h0500, 0, 7, 1'b0);
        do_load(1, 16'h0600, 0, -1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            do_load(int'($urandom_range(3)), 16'($urandom), 2,
                    ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
